mem_arbiter: RTL and testbench

- Single-channel request scheduler in front of the byte-serial memory controller. It shares that controller between three requesters: instruction fetch, speculative load, and committed store.
- Grants one transaction at a time and issues it downstream as a one-cycle request pulse. It then waits for the downstream completion and routes the result back to the owner.
- Applies fixed priority with a fetch anti-starvation override.
- Flushes speculative traffic on rollback. Committed stores are never dropped.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Request scheduler for the byte-serial memory controller. Three requesters
// (fetch, load, store) share one downstream channel; one transaction is in
// flight at a time. Fixed priority store > load > fetch, with a starvation
// override for fetch. Rollback flushes speculative traffic; stores always finish.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_rollback,
    input  logic        in_fetch_req,
    input  logic [31:0] in_fetch_addr,
    output logic        out_fetch_ok,
    output logic [31:0] out_fetch_data,
    input  logic        in_load_req,
    input  logic [31:0] in_load_addr,
    input  logic [2:0]  in_load_size,
    output logic        out_load_ok,
    output logic [31:0] out_load_data,
    input  logic        in_store_req,
    input  logic [31:0] in_store_addr,
    input  logic [2:0]  in_store_size,
    input  logic [31:0] in_store_data,
    output logic        out_store_ok,
    output logic        out_mem_ena,
    output logic        out_mem_iswrite,
    output logic [31:0] out_mem_addr,
    output logic [2:0]  out_mem_size,
    output logic [31:0] out_mem_data,
    input  logic        in_mem_ok,
    input  logic [31:0] in_mem_data
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD, OWN_STORE} owner_t;

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    state_t               state, state_nxt;
    owner_t               owner, owner_nxt;
    logic [CNT_WIDTH-1:0] starve_cnt;

    logic fetch_elig, load_elig, store_elig, force_fetch;
    logic gnt_fetch, gnt_load, gnt_store, deliver;

    // A requester whose ok is pulsing this cycle is masked so it is not
    // re-granted on its own stale request; rollback kills speculative requests.
    assign fetch_elig  = in_fetch_req && !out_fetch_ok && !in_rollback;
    assign load_elig   = in_load_req  && !out_load_ok  && !in_rollback;
    assign store_elig  = in_store_req && !out_store_ok;
    assign force_fetch = fetch_elig && (starve_cnt == LIMIT);

    // State and owner registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= OWN_NONE;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Next-state, grant selection and completion routing
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        gnt_fetch = 1'b0;
        gnt_load  = 1'b0;
        gnt_store = 1'b0;
        deliver   = 1'b0;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (force_fetch)     gnt_fetch = 1'b1;
                    else if (store_elig) gnt_store = 1'b1;
                    else if (load_elig)  gnt_load  = 1'b1;
                    else if (fetch_elig) gnt_fetch = 1'b1;
                    if (gnt_fetch) begin
                        state_nxt = BUSY;
                        owner_nxt = OWN_FETCH;
                    end else if (gnt_store) begin
                        state_nxt = BUSY;
                        owner_nxt = OWN_STORE;
                    end else if (gnt_load) begin
                        state_nxt = BUSY;
                        owner_nxt = OWN_LOAD;
                    end
                end
                BUSY: begin
                    if (in_rollback && owner != OWN_STORE) begin
                        // Speculative result is dead; a completion in this same
                        // cycle is simply swallowed.
                        state_nxt = in_mem_ok ? IDLE : DRAIN;
                        owner_nxt = in_mem_ok ? OWN_NONE : owner;
                    end else if (in_mem_ok) begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                        owner_nxt = OWN_NONE;
                    end
                end
                DRAIN: begin
                    if (in_mem_ok) begin
                        state_nxt = IDLE;
                        owner_nxt = OWN_NONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    owner_nxt = OWN_NONE;
                end
            endcase
        end
    end

    // Downstream request registers, ok pulses and returned data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_fetch_ok    <= 1'b0;
            out_fetch_data  <= '0;
            out_load_ok     <= 1'b0;
            out_load_data   <= '0;
            out_store_ok    <= 1'b0;
            out_mem_ena     <= 1'b0;
            out_mem_iswrite <= 1'b0;
            out_mem_addr    <= '0;
            out_mem_size    <= '0;
            out_mem_data    <= '0;
        end else begin
            out_fetch_ok <= 1'b0;
            out_load_ok  <= 1'b0;
            out_store_ok <= 1'b0;
            out_mem_ena  <= 1'b0;
            if (gnt_fetch) begin
                out_mem_ena     <= 1'b1;
                out_mem_iswrite <= 1'b0;
                out_mem_addr    <= in_fetch_addr;
                out_mem_size    <= 3'd4;
                out_mem_data    <= '0;
            end else if (gnt_store) begin
                out_mem_ena     <= 1'b1;
                out_mem_iswrite <= 1'b1;
                out_mem_addr    <= in_store_addr;
                out_mem_size    <= in_store_size;
                out_mem_data    <= in_store_data;
            end else if (gnt_load) begin
                out_mem_ena     <= 1'b1;
                out_mem_iswrite <= 1'b0;
                out_mem_addr    <= in_load_addr;
                out_mem_size    <= in_load_size;
                out_mem_data    <= '0;
            end
            if (deliver) begin
                case (owner)
                    OWN_FETCH: begin
                        out_fetch_ok   <= 1'b1;
                        out_fetch_data <= in_mem_data;
                    end
                    OWN_LOAD: begin
                        out_load_ok   <= 1'b1;
                        out_load_data <= in_mem_data;
                    end
                    OWN_STORE: out_store_ok <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Starvation counter: counts non-fetch grants that bypassed a waiting fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (ena) begin
            if (gnt_fetch || !in_fetch_req || in_rollback)
                starve_cnt <= '0;
            else if ((gnt_store || gnt_load) && fetch_elig && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the downstream controller is played by hand,
// outputs are sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

    logic        clk, rst, ena, in_rollback;
    logic        in_fetch_req, out_fetch_ok;
    logic [31:0] in_fetch_addr, out_fetch_data;
    logic        in_load_req, out_load_ok;
    logic [31:0] in_load_addr, out_load_data;
    logic [2:0]  in_load_size;
    logic        in_store_req, out_store_ok;
    logic [31:0] in_store_addr, in_store_data;
    logic [2:0]  in_store_size;
    logic        out_mem_ena, out_mem_iswrite;
    logic [31:0] out_mem_addr, out_mem_data;
    logic [2:0]  out_mem_size;
    logic        in_mem_ok;
    logic [31:0] in_mem_data;

    int nvec = 0;
    int nerr = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_rollback(in_rollback),
        .in_fetch_req(in_fetch_req), .in_fetch_addr(in_fetch_addr),
        .out_fetch_ok(out_fetch_ok), .out_fetch_data(out_fetch_data),
        .in_load_req(in_load_req), .in_load_addr(in_load_addr),
        .in_load_size(in_load_size), .out_load_ok(out_load_ok),
        .out_load_data(out_load_data),
        .in_store_req(in_store_req), .in_store_addr(in_store_addr),
        .in_store_size(in_store_size), .in_store_data(in_store_data),
        .out_store_ok(out_store_ok),
        .out_mem_ena(out_mem_ena), .out_mem_iswrite(out_mem_iswrite),
        .out_mem_addr(out_mem_addr), .out_mem_size(out_mem_size),
        .out_mem_data(out_mem_data),
        .in_mem_ok(in_mem_ok), .in_mem_data(in_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fok"},  32'(out_fetch_ok),    32'h0);
        chk({tag, "_fdat"}, out_fetch_data,       32'h0);
        chk({tag, "_lok"},  32'(out_load_ok),     32'h0);
        chk({tag, "_ldat"}, out_load_data,        32'h0);
        chk({tag, "_sok"},  32'(out_store_ok),    32'h0);
        chk({tag, "_mena"}, 32'(out_mem_ena),     32'h0);
        chk({tag, "_mwr"},  32'(out_mem_iswrite), 32'h0);
        chk({tag, "_madr"}, out_mem_addr,         32'h0);
        chk({tag, "_msz"},  32'(out_mem_size),    32'h0);
        chk({tag, "_mdat"}, out_mem_data,         32'h0);
    endtask

    task automatic chk_req(input string tag, input logic wr, input logic [31:0] adr,
                           input logic [2:0] sz, input logic [31:0] dat);
        chk({tag, "_ena"},  32'(out_mem_ena),     32'h1);
        chk({tag, "_wr"},   32'(out_mem_iswrite), 32'(wr));
        chk({tag, "_addr"}, out_mem_addr,         adr);
        chk({tag, "_size"}, 32'(out_mem_size),    32'(sz));
        chk({tag, "_data"}, out_mem_data,         dat);
    endtask

    initial begin
        rst = 1'b0; ena = 1'b1; in_rollback = 1'b0;
        in_fetch_req = 1'b0; in_fetch_addr = '0;
        in_load_req = 1'b0; in_load_addr = '0; in_load_size = '0;
        in_store_req = 1'b0; in_store_addr = '0; in_store_size = '0; in_store_data = '0;
        in_mem_ok = 1'b0; in_mem_data = '0;

        // ---- reset state
        tick();
        chk_all_zero("rst");
        rst = 1'b1;
        tick();

        // ---- fetch only, completion 5 cycles after the request pulse
        in_fetch_req = 1'b1; in_fetch_addr = 32'h0000_1000;
        tick();
        chk_req("f1_req", 1'b0, 32'h0000_1000, 3'd4, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("f1_nopulse", 32'(out_mem_ena), 32'h0);
        end
        in_mem_ok = 1'b1; in_mem_data = 32'h0051_3023;
        tick();
        in_mem_ok = 1'b0; in_mem_data = '0;
        chk("f1_ok", 32'(out_fetch_ok), 32'h1);
        chk("f1_data", out_fetch_data, 32'h0051_3023);
        tick();  // fetch still high during its ok cycle: must be masked
        chk("f1_noregrant", 32'(out_mem_ena), 32'h0);
        chk("f1_okonce", 32'(out_fetch_ok), 32'h0);
        chk("f1_hold", out_fetch_data, 32'h0051_3023);
        in_fetch_req = 1'b0;
        tick();

        // ---- all three at once: store, then load, then fetch
        in_store_req = 1'b1; in_store_addr = 32'h40; in_store_size = 3'd4; in_store_data = 32'hDEAD_BEEF;
        in_load_req = 1'b1; in_load_addr = 32'h80; in_load_size = 3'd4;
        in_fetch_req = 1'b1; in_fetch_addr = 32'h100;
        tick();
        chk_req("m_st", 1'b1, 32'h40, 3'd4, 32'hDEAD_BEEF);
        tick();
        in_mem_ok = 1'b1;
        tick();
        in_mem_ok = 1'b0;
        chk("m_st_ok", 32'(out_store_ok), 32'h1);
        chk("m_st_lok", 32'(out_load_ok), 32'h0);
        in_store_req = 1'b0;
        tick();
        chk_req("m_ld", 1'b0, 32'h80, 3'd4, 32'h0);
        tick();
        in_mem_ok = 1'b1; in_mem_data = 32'h0000_00AB;
        tick();
        in_mem_ok = 1'b0;
        chk("m_ld_ok", 32'(out_load_ok), 32'h1);
        chk("m_ld_data", out_load_data, 32'h0000_00AB);
        chk("m_ld_fok", 32'(out_fetch_ok), 32'h0);
        in_load_req = 1'b0;
        tick();
        chk_req("m_f", 1'b0, 32'h100, 3'd4, 32'h0);
        tick();
        in_mem_ok = 1'b1; in_mem_data = 32'h1111_1111;
        tick();
        in_mem_ok = 1'b0;
        chk("m_f_ok", 32'(out_fetch_ok), 32'h1);
        chk("m_f_data", out_fetch_data, 32'h1111_1111);
        in_fetch_req = 1'b0;
        tick();

        // ---- starvation: fetch held, load re-requested back-to-back.
        // ena is dropped for the ok cycle so the load mask lifts before the
        // next arbitration, letting load contend every time.
        in_fetch_req = 1'b1; in_fetch_addr = 32'h200;
        in_load_req = 1'b1; in_load_addr = 32'h300; in_load_size = 3'd2;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_req("sv_ld", 1'b0, 32'h300, 3'd2, 32'h0);
            tick();
            in_mem_ok = 1'b1; in_mem_data = 32'(i);
            tick();
            in_mem_ok = 1'b0;
            chk("sv_ld_ok", 32'(out_load_ok), 32'h1);
            chk("sv_ld_data", out_load_data, 32'(i));
            ena = 1'b0;
            tick();
            chk("sv_gate", 32'(out_mem_ena), 32'h0);
            chk("sv_okclr", 32'(out_load_ok), 32'h0);
            ena = 1'b1;
        end
        tick();
        chk_req("sv_force", 1'b0, 32'h200, 3'd4, 32'h0);
        tick();
        in_mem_ok = 1'b1; in_mem_data = 32'h2222_2222;
        tick();
        in_mem_ok = 1'b0;
        chk("sv_f_ok", 32'(out_fetch_ok), 32'h1);
        in_fetch_req = 1'b0;
        tick();
        chk_req("sv_ld_after", 1'b0, 32'h300, 3'd2, 32'h0);
        tick();
        in_mem_ok = 1'b1; in_mem_data = 32'h5555;
        tick();
        in_mem_ok = 1'b0;
        chk("sv_ld5_data", out_load_data, 32'h5555);
        in_load_req = 1'b0;
        tick();

        // ---- rollback one cycle after a load grant -> drain, no ok
        in_load_req = 1'b1; in_load_addr = 32'h84; in_load_size = 3'd1;
        tick();
        chk_req("rb_ld", 1'b0, 32'h84, 3'd1, 32'h0);
        in_rollback = 1'b1; in_load_req = 1'b0;
        tick();
        in_rollback = 1'b0;
        tick();
        in_mem_ok = 1'b1; in_mem_data = 32'h1234;
        tick();
        in_mem_ok = 1'b0;
        chk("rb_nook", 32'(out_load_ok), 32'h0);
        chk("rb_data_kept", out_load_data, 32'h5555);
        chk("rb_nopulse", 32'(out_mem_ena), 32'h0);
        in_fetch_req = 1'b1; in_fetch_addr = 32'h400;
        tick();
        chk_req("rb_f", 1'b0, 32'h400, 3'd4, 32'h0);
        tick();
        in_mem_ok = 1'b1; in_mem_data = 32'h77;
        tick();
        in_mem_ok = 1'b0;
        chk("rb_f_ok", 32'(out_fetch_ok), 32'h1);
        chk("rb_f_data", out_fetch_data, 32'h77);
        in_fetch_req = 1'b0;
        tick();

        // ---- rollback during a store: store completes; speculative reqs flushed
        in_store_req = 1'b1; in_store_addr = 32'h500; in_store_size = 3'd1; in_store_data = 32'hA5;
        tick();
        chk_req("rs_st", 1'b1, 32'h500, 3'd1, 32'hA5);
        in_rollback = 1'b1; in_fetch_req = 1'b1; in_load_req = 1'b1; in_load_addr = 32'h600;
        tick();
        in_rollback = 1'b0; in_fetch_req = 1'b0; in_load_req = 1'b0;
        in_mem_ok = 1'b1;
        tick();
        in_mem_ok = 1'b0;
        chk("rs_st_ok", 32'(out_store_ok), 32'h1);
        in_store_req = 1'b0;
        in_rollback = 1'b1; in_fetch_req = 1'b1; in_load_req = 1'b1;
        tick();
        chk("rs_idle_flush", 32'(out_mem_ena), 32'h0);
        in_rollback = 1'b0; in_fetch_req = 1'b0; in_load_req = 1'b0;
        tick();

        // ---- reset in the middle of BUSY
        in_load_req = 1'b1; in_load_addr = 32'h700; in_load_size = 3'd4;
        tick();
        chk_req("rm_ld", 1'b0, 32'h700, 3'd4, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk_all_zero("rm_async");
        in_load_req = 1'b0;
        tick();
        tick();
        chk_all_zero("rm_held");
        rst = 1'b1;
        in_store_req = 1'b1; in_store_addr = 32'h800; in_store_size = 3'd2; in_store_data = 32'h1234;
        tick();
        chk_req("rm_st", 1'b1, 32'h800, 3'd2, 32'h1234);
        tick();
        in_mem_ok = 1'b1;
        tick();
        in_mem_ok = 1'b0;
        chk("rm_st_ok", 32'(out_store_ok), 32'h1);
        in_store_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
